// File: rtl/tsc_mem_pkg.sv
// Shared constants and FSM encoding for the TSC memory responder.
package tsc_mem_pkg;

    // Data/address width of the cpu bus.
    localparam int WORD_SIZE = 16;

    // Legal READ_LATENCY range; the counter is sized for the upper bound.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 15;
    localparam int CNT_W      = 4;

    // Responder FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_DRIVE = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/tsc_mem_array.sv
// DEPTH x WORD_SIZE word store: synchronous write, asynchronous read.
// Contents are never reset; they are preloaded through the write port.
module tsc_mem_array #(
    parameter int WORD_SIZE = tsc_mem_pkg::WORD_SIZE,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WORD_SIZE-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    // Backdoor write port.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read sees the pre-edge contents, so a same-edge write is not visible.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tsc_mem_responder.sv
// Memory responder for the TSC cpu: answers readM with a word on the shared
// data bus after READ_LATENCY edges, pulsing inputReady for one cycle.
module tsc_mem_responder #(
    parameter int WORD_SIZE    = tsc_mem_pkg::WORD_SIZE,
    parameter int ADDR_BITS    = 8,
    parameter int READ_LATENCY = 2   // 1..15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [WORD_SIZE-1:0] load_data,
    output logic [WORD_SIZE-1:0] num_reads
);

    import tsc_mem_pkg::*;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [WORD_SIZE-1:0] nr_q, nr_d;
    logic [WORD_SIZE-1:0] rd_word;
    logic                 drive_en;

    // Upper address bits are intentionally ignored (addresses wrap).
    generate
        if (ADDR_BITS < WORD_SIZE) begin : g_addr_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];
        end
    endgenerate

    tsc_mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .we_i    (load_en),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (idx_q),
        .rdata_o (rd_word)
    );

    // Next-state logic: latch index, count latency, capture word, then hold
    // off until readM drops so a held request cannot re-trigger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        nr_d    = nr_q;
        case (state_q)
            ST_IDLE: begin
                if (readM) begin
                    idx_d   = address[ADDR_BITS-1:0];
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!readM) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    data_d  = rd_word;
                    state_d = ST_DRIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DRIVE: begin
                nr_d    = nr_q + 1'b1;
                state_d = readM ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!readM) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            nr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            nr_q    <= nr_d;
        end
    end

    // Outputs are pure decodes of registered state; single bus driver.
    assign drive_en   = (state_q == ST_DRIVE);
    assign inputReady = drive_en;
    assign data       = drive_en ? data_q : {WORD_SIZE{1'bz}};
    assign num_reads  = nr_q;

endmodule
